// File: rtl/router_rd_port.sv
// Read-side controller for one router output port: drains the port FIFO to the
// destination, tracks header/payload/parity framing and raises a stall soft reset.
module router_rd_port #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_fifo_empty,
  input  logic [DW:0]   i_fifo_dout,
  output logic          o_fifo_rd_en,
  input  logic          i_read_enb,
  output logic          o_vld_out,
  output logic [DW-1:0] o_data_out,
  output logic          o_sftrst,
  output logic          o_pkt_done,
  output logic          o_parity_err,
  output logic          o_sync_err,
  output logic [1:0]    o_state
);

  localparam int LW = DW - 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [LW-1:0]   r_len_cnt, w_len_nxt;
  logic [DW-1:0]   r_acc, w_acc_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic [DW-1:0]   r_data_out, w_data_nxt;
  logic            r_sftrst, w_sftrst_nxt;
  logic            r_pkt_done, w_pkt_done_nxt;
  logic            r_parity_err, w_parity_err_nxt;
  logic            r_sync_err, w_sync_err_nxt;

  logic            w_vld;
  logic            w_user_pop;
  logic            w_drop;
  logic            w_take;
  logic            w_stall;
  logic [DW-1:0]   w_byte;

  assign w_byte     = i_fifo_dout[DW-1:0];
  assign w_vld      = !i_fifo_empty && !r_sftrst;
  assign w_user_pop = w_vld && i_read_enb;
  assign w_drop     = (r_state == S_IDLE) && !i_fifo_empty && !i_fifo_dout[DW] && !r_sftrst;
  // A stray word at an idle head is discarded even if the destination is reading.
  assign w_take     = w_user_pop && !w_drop;
  assign w_stall    = w_vld && !i_read_enb;

  assign o_vld_out    = w_vld;
  assign o_fifo_rd_en = w_user_pop || w_drop;
  assign o_data_out   = r_data_out;
  assign o_sftrst     = r_sftrst;
  assign o_pkt_done   = r_pkt_done;
  assign o_parity_err = r_parity_err;
  assign o_sync_err   = r_sync_err;
  assign o_state      = r_state;

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len_cnt;
    w_acc_nxt        = r_acc;
    w_to_nxt         = r_to_cnt;
    w_data_nxt       = r_data_out;
    w_sftrst_nxt     = 1'b0;
    w_pkt_done_nxt   = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;
    if (r_sftrst) begin
      w_state_nxt = S_IDLE;
      w_len_nxt   = '0;
      w_acc_nxt   = '0;
      w_to_nxt    = '0;
    end else begin
      if (w_stall) begin
        if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_to_nxt     = '0;
          w_sftrst_nxt = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end else begin
        w_to_nxt = '0;
      end
      if (w_drop) begin
        w_sync_err_nxt = 1'b1;
      end else if (w_take) begin
        w_data_nxt = w_byte;
        case (r_state)
          S_IDLE: begin
            w_len_nxt   = w_byte[DW-1:2];
            w_acc_nxt   = w_byte;
            w_state_nxt = (w_byte[DW-1:2] != '0) ? S_PAYLOAD : S_PARITY;
          end
          S_PAYLOAD: begin
            w_acc_nxt = r_acc ^ w_byte;
            w_len_nxt = r_len_cnt - LW'(1);
            if (r_len_cnt == LW'(1)) w_state_nxt = S_PARITY;
          end
          S_PARITY: begin
            w_pkt_done_nxt   = 1'b1;
            w_parity_err_nxt = (w_byte != r_acc);
            w_acc_nxt        = '0;
            w_state_nxt      = S_IDLE;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_len_cnt    <= '0;
      r_acc        <= '0;
      r_to_cnt     <= '0;
      r_data_out   <= '0;
      r_sftrst     <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len_cnt    <= w_len_nxt;
      r_acc        <= w_acc_nxt;
      r_to_cnt     <= w_to_nxt;
      r_data_out   <= w_data_nxt;
      r_sftrst     <= w_sftrst_nxt;
      r_pkt_done   <= w_pkt_done_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_sync_err   <= w_sync_err_nxt;
    end
  end

endmodule
